hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
Pipeline hazard controller that sits beside the instruction decode stage. It tracks in-flight register writes with a per-register pending counter, sequences IF/ID stalls and EX bubble insertion for read-after-write and write-after-write hazards, and clears pending state on writeback. A jump/flush handshake drops the instruction held in decode.

Parameters:
NREG, 32, number of architectural registers (register 0 hardwired, never tracked)
AW, 5, register address width, equal to log2(NREG)
CNTW, 2, pending-counter width; max in-flight writes per register = 2^CNTW-1

Ports:
clk  in  1  clock, all state updates on posedge
reset  in  1  asynchronous, active-high
id_valid  in  1  decode stage holds a valid instruction
id_rs  in  AW  source register 1 address
id_rt  in  AW  source register 2 address
id_rs_used  in  1  instruction reads id_rs
id_rt_used  in  1  instruction reads id_rt
id_dst  in  AW  destination register address
id_dst_wr  in  1  instruction writes id_dst (control-unit reg_write)
wb_valid  in  1  writeback stage writes the register file this cycle
wb_addr  in  AW  writeback register address
flush  in  1  jump/branch taken; discard the decode instruction
issue  out  1  decode instruction advances to EX this cycle
stall_if  out  1  hold PC and IF/ID register
stall_id  out  1  hold decode stage
bubble_ex  out  1  inject NOP into ID/EX register
busy_mask  out  NREG  registered; bit i = pending[i] != 0
stall_cnt  out  16  registered saturating count of stall cycles
err_underflow  out  1  registered sticky; writeback to a register with no pending write

Behaviour:
- Reset (async): all pending counters 0, FSM = RUN, busy_mask 0, stall_cnt 0, err_underflow 0. Combinational outputs follow the rules below; with id_valid=0 all four are 0.
- Register 0: never hazards, never counted; wb to 0 ignored (no error).
- raw = id_valid & ((id_rs_used & id_rs!=0 & pending[id_rs]!=0) | (id_rt_used & id_rt!=0 & pending[id_rt]!=0)).
- sat = id_valid & id_dst_wr & id_dst!=0 & pending[id_dst]==2^CNTW-1.
- hazard = raw | sat. Uses registered counts only; same-cycle writeback does NOT clear a hazard (one extra stall cycle, by design).
- FSM states RUN, STALL, FLUSH:
  - RUN: flush -> FLUSH; else hazard -> STALL; else stay.
  - STALL: flush -> FLUSH; else !hazard -> RUN; else stay.
  - FLUSH: one cycle, then -> RUN (or STALL if hazard is present on that cycle).
- Outputs (combinational from state and inputs):
  - issue = id_valid & !hazard & !flush & state!=FLUSH.
  - stall_if = stall_id = hazard & !flush & state!=FLUSH.
  - bubble_ex = id_valid & !issue, or state==FLUSH.
- Flush has priority over hazard. A flushed instruction never increments a counter.
- Counters, per posedge:
  - inc = issue & id_dst_wr & id_dst!=0 on id_dst.
  - dec = wb_valid & wb_addr!=0 on wb_addr.
  - inc and dec on the same register in the same cycle: net unchanged.
  - dec when the count is 0: count stays 0 and err_underflow is set (cleared only by reset).
  - sat guarantees inc never overflows.
- stall_cnt increments on every cycle with stall_if=1 and saturates at 16'hFFFF.
- busy_mask reflects the counter values after the update.
- Reset mid-operation clears all in-flight tracking immediately; the pipeline must be flushed externally.

Decomposition:
- Package hazard_pkg: FSM state enum (RUN, STALL, FLUSH), REG_ZERO constant, default AW/CNTW.
- Sub-module pend_counter: CNTW-bit up/down counter with inc, dec, zero/full flags and an underflow pulse. Instantiated NREG-1 times (registers 1..NREG-1).

Test Plan:
- Issue add r3 (dst_wr, dst=3); next cycle rs=3 used -> stall_if=stall_id=1, bubble_ex=1, busy_mask[3]=1. wb_valid with wb_addr=3 -> stall held that cycle, cleared the next; issue=1, stall_cnt=2.
- Instruction with rs=0, rt=0 while pending[0] is targeted by a write -> no stall, busy_mask=0.
- Three issues writing r5 with no writeback -> pending[5]=3. A fourth write to r5 -> sat stall; one wb to r5 -> issue resumes, pending[5]=3.
- Same-cycle issue write to r7 and wb to r7 with pending[7]=1 -> pending[7] stays 1, busy_mask[7]=1.
- Hazard on r4 in STALL, then flush=1 -> issue=0, bubble_ex=1, next state FLUSH; pending counts unchanged, then return to STALL/RUN per the rules.
- wb_valid to r9 with pending[9]=0 -> err_underflow=1 and sticky. Assert reset mid-stall -> all outputs 0, busy_mask=0, state RUN.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and defaults for the decode-stage hazard scoreboard.
package hazard_pkg;

  localparam int unsigned NREG_DEF = 32;
  localparam int unsigned AW_DEF   = 5;
  localparam int unsigned CNTW_DEF = 2;
  localparam int unsigned REG_ZERO = 0;
  localparam int unsigned SCW      = 16;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Decode/writeback/flush bus between the pipeline and the hazard scoreboard.
interface hazard_scoreboard_if
  import hazard_pkg::*;
#(
  parameter int unsigned NREG = NREG_DEF,
  parameter int unsigned AW   = AW_DEF
);
  logic          id_valid;
  logic [AW-1:0] id_rs;
  logic [AW-1:0] id_rt;
  logic          id_rs_used;
  logic          id_rt_used;
  logic [AW-1:0] id_dst;
  logic          id_dst_wr;
  logic          wb_valid;
  logic [AW-1:0] wb_addr;
  logic          flush;
  logic            issue;
  logic            stall_if;
  logic            stall_id;
  logic            bubble_ex;
  logic [NREG-1:0] busy_mask;
  logic [SCW-1:0]  stall_cnt;
  logic            err_underflow;

  modport master (
    output id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_dst, id_dst_wr,
           wb_valid, wb_addr, flush,
    input  issue, stall_if, stall_id, bubble_ex, busy_mask, stall_cnt, err_underflow
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_dst, id_dst_wr,
           wb_valid, wb_addr, flush,
    output issue, stall_if, stall_id, bubble_ex, busy_mask, stall_cnt, err_underflow
  );
endinterface

// File: rtl/pend_counter.sv
// Per-register in-flight write counter; inc and dec together leave the count unchanged.
module pend_counter #(
  parameter int unsigned CNTW = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic dec,
  output logic zero_c,
  output logic full_c,
  output logic underflow_c
);

  logic [CNTW-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (inc && !dec) begin
      count <= count + CNTW'(1);
    end else if (dec && !inc && count != '0) begin
      count <= count - CNTW'(1);
    end
  end

  assign zero_c      = (count == '0);
  assign full_c      = (count == '1);
  // A writeback with nothing outstanding is a protocol error seen by the parent.
  assign underflow_c = dec & zero_c;

endmodule

// File: rtl/hazard_scoreboard.sv
// RAW/WAW hazard scoreboard: per-register pending counts, stall/bubble sequencing, flush handling.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int unsigned NREG = NREG_DEF,
  parameter int unsigned AW   = AW_DEF,
  parameter int unsigned CNTW = CNTW_DEF
) (
  input logic                clk,
  input logic                reset,
  hazard_scoreboard_if.slave bus
);

  logic [NREG-1:1] zero_vec, full_vec, inc_vec, dec_vec, uf_vec;
  logic [NREG-1:0] busy, full_all;
  state_e          state, state_n;
  logic            raw, sat, hazard;
  logic            issue, stall, bubble;
  logic [SCW-1:0]  stall_cnt;
  logic            err_q;

  // Register 0 is never tracked, so its busy/full bits are tied low.
  assign busy     = {~zero_vec, 1'b0};
  assign full_all = {full_vec, 1'b0};

  for (genvar i = REG_ZERO + 1; i < int'(NREG); i++) begin : g_reg
    assign inc_vec[i] = issue & bus.id_dst_wr & (bus.id_dst == AW'(i));
    assign dec_vec[i] = bus.wb_valid & (bus.wb_addr == AW'(i));

    pend_counter #(.CNTW(CNTW)) u_cnt (
      .clk         (clk),
      .reset       (reset),
      .inc         (inc_vec[i]),
      .dec         (dec_vec[i]),
      .zero_c      (zero_vec[i]),
      .full_c      (full_vec[i]),
      .underflow_c (uf_vec[i])
    );
  end

  // Hazard uses registered counts only; a same-cycle writeback still stalls once.
  assign raw = bus.id_valid & ((bus.id_rs_used & busy[bus.id_rs]) |
                               (bus.id_rt_used & busy[bus.id_rt]));
  assign sat    = bus.id_valid & bus.id_dst_wr & full_all[bus.id_dst];
  assign hazard = raw | sat;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_RUN;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    issue   = 1'b0;
    stall   = 1'b0;
    bubble  = 1'b0;
    case (state)
      ST_RUN, ST_STALL: begin
        if (bus.flush)   state_n = ST_FLUSH;
        else if (hazard) state_n = ST_STALL;
        else             state_n = ST_RUN;
      end
      ST_FLUSH: state_n = hazard ? ST_STALL : ST_RUN;
      default:  state_n = ST_RUN;
    endcase
    issue  = bus.id_valid & ~hazard & ~bus.flush & (state != ST_FLUSH);
    stall  = hazard & ~bus.flush & (state != ST_FLUSH);
    bubble = (bus.id_valid & ~issue) | (state == ST_FLUSH);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
      err_q     <= 1'b0;
    end else begin
      if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + SCW'(1);
      if (|uf_vec) err_q <= 1'b1;
    end
  end

  assign bus.issue         = issue;
  assign bus.stall_if      = stall;
  assign bus.stall_id      = stall;
  assign bus.bubble_ex     = bubble;
  assign bus.busy_mask     = busy;
  assign bus.stall_cnt     = stall_cnt;
  assign bus.err_underflow = err_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed table plus randomized run of hazard_scoreboard against a behavioural scoreboard model.
module tb_hazard_scoreboard;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hazard_scoreboard_if #(.NREG(32), .AW(5)) bus ();

  hazard_scoreboard #(.NREG(32), .AW(5), .CNTW(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    bit          v, rsu, rtu, wr, wbv, fl;
    logic [4:0]  rs, rt, dst, wba;
    bit          e_issue, e_stall, e_bub, e_err;
    logic [31:0] e_busy;
    logic [15:0] e_scnt;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // Reference: pending[] counts, mode 0=run 1=stall 2=flush-recovery cycle
  int pend[32];
  int mmode;
  int mscnt;
  bit merr;

  function automatic vec_t mk(int v, int rs, int rt, int rsu, int rtu, int dst, int wr,
                              int wbv, int wba, int fl, int ei, int es, int eb,
                              int ebusy, int escnt, int eerr);
    vec_t r;
    r.v = (v != 0); r.rs = 5'(rs); r.rt = 5'(rt); r.rsu = (rsu != 0); r.rtu = (rtu != 0);
    r.dst = 5'(dst); r.wr = (wr != 0); r.wbv = (wbv != 0); r.wba = 5'(wba); r.fl = (fl != 0);
    r.e_issue = (ei != 0); r.e_stall = (es != 0); r.e_bub = (eb != 0);
    r.e_busy = 32'(ebusy); r.e_scnt = 16'(escnt); r.e_err = (eerr != 0);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    foreach (pend[i]) pend[i] = 0;
    mmode = 0; mscnt = 0; merr = 1'b0;
  endfunction

  function automatic bit model_hazard(input vec_t v);
    bit raw, sat;
    raw = v.v && ((v.rsu && v.rs != 0 && pend[v.rs] > 0) ||
                  (v.rtu && v.rt != 0 && pend[v.rt] > 0));
    sat = v.v && v.wr && v.dst != 0 && pend[v.dst] == 3;
    return raw || sat;
  endfunction

  function automatic logic [31:0] model_busy();
    logic [31:0] m = '0;
    for (int i = 1; i < 32; i++) if (pend[i] > 0) m[i] = 1'b1;
    return m;
  endfunction

  task automatic drive(input vec_t v);
    bus.id_valid = v.v; bus.id_rs = v.rs; bus.id_rt = v.rt;
    bus.id_rs_used = v.rsu; bus.id_rt_used = v.rtu;
    bus.id_dst = v.dst; bus.id_dst_wr = v.wr;
    bus.wb_valid = v.wbv; bus.wb_addr = v.wba; bus.flush = v.fl;
  endtask

  // One clock: check combinational outputs mid-cycle, advance model, check registered outputs.
  task automatic step(input vec_t v, input bit use_tab, input string tag);
    bit hz, iss, stl, bub;
    @(negedge clk);
    drive(v);
    #1;
    hz  = model_hazard(v);
    iss = v.v && !hz && !v.fl && mmode != 2;
    stl = hz && !v.fl && mmode != 2;
    bub = (v.v && !iss) || mmode == 2;
    if (use_tab) begin iss = v.e_issue; stl = v.e_stall; bub = v.e_bub; end
    chk({tag, " issue"},     32'(bus.issue),     32'(iss));
    chk({tag, " stall_if"},  32'(bus.stall_if),  32'(stl));
    chk({tag, " stall_id"},  32'(bus.stall_id),  32'(stl));
    chk({tag, " bubble_ex"}, 32'(bus.bubble_ex), 32'(bub));
    @(posedge clk);
    if (stl && mscnt < 65535) mscnt++;
    if (mmode == 2)   mmode = hz ? 1 : 0;
    else if (v.fl)    mmode = 2;
    else              mmode = hz ? 1 : 0;
    if (v.wbv && v.wba != 0 && pend[v.wba] == 0) merr = 1'b1;
    if (iss && v.wr && v.dst != 0 && v.wbv && v.wba == v.dst) begin
    end else begin
      if (iss && v.wr && v.dst != 0) pend[v.dst]++;
      if (v.wbv && v.wba != 0 && pend[v.wba] > 0) pend[v.wba]--;
    end
    #1;
    if (use_tab) begin
      chk({tag, " busy_mask"}, bus.busy_mask, v.e_busy);
      chk({tag, " stall_cnt"}, 32'(bus.stall_cnt), 32'(v.e_scnt));
      chk({tag, " err"},       32'(bus.err_underflow), 32'(v.e_err));
    end else begin
      chk({tag, " busy_mask"}, bus.busy_mask, model_busy());
      chk({tag, " stall_cnt"}, 32'(bus.stall_cnt), 32'(mscnt));
      chk({tag, " err"},       32'(bus.err_underflow), 32'(merr));
    end
  endtask

  vec_t tab[27];
  vec_t rv;
  int   cand[8];
  int   nc;

  initial begin
    //            v rs rt su tu dst wr wbv wba fl  iss stl bub busy   scnt err
    tab[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 'h00, 0, 0);
    tab[1]  = mk(1, 0, 0, 0, 0, 3, 1, 0, 0, 0,  1, 0, 0, 'h08, 0, 0);
    tab[2]  = mk(1, 3, 0, 1, 0, 4, 1, 0, 0, 0,  0, 1, 1, 'h08, 1, 0);
    tab[3]  = mk(1, 3, 0, 1, 0, 4, 1, 1, 3, 0,  0, 1, 1, 'h00, 2, 0);
    tab[4]  = mk(1, 3, 0, 1, 0, 4, 1, 0, 0, 0,  1, 0, 0, 'h10, 2, 0);
    tab[5]  = mk(1, 0, 0, 1, 1, 0, 1, 1, 4, 0,  1, 0, 0, 'h00, 2, 0);
    tab[6]  = mk(1, 1, 2, 0, 0, 5, 1, 0, 0, 0,  1, 0, 0, 'h20, 2, 0);
    tab[7]  = mk(1, 1, 2, 0, 0, 5, 1, 0, 0, 0,  1, 0, 0, 'h20, 2, 0);
    tab[8]  = mk(1, 1, 2, 0, 0, 5, 1, 0, 0, 0,  1, 0, 0, 'h20, 2, 0);
    tab[9]  = mk(1, 1, 2, 0, 0, 5, 1, 0, 0, 0,  0, 1, 1, 'h20, 3, 0);
    tab[10] = mk(1, 1, 2, 0, 0, 5, 1, 1, 5, 0,  0, 1, 1, 'h20, 4, 0);
    tab[11] = mk(1, 1, 2, 0, 0, 5, 1, 0, 0, 0,  1, 0, 0, 'h20, 4, 0);
    tab[12] = mk(1, 0, 0, 0, 0, 7, 1, 0, 0, 0,  1, 0, 0, 'hA0, 4, 0);
    tab[13] = mk(1, 0, 0, 0, 0, 7, 1, 1, 7, 0,  1, 0, 0, 'hA0, 4, 0);
    tab[14] = mk(1, 0, 0, 0, 0, 4, 1, 0, 0, 0,  1, 0, 0, 'hB0, 4, 0);
    tab[15] = mk(1, 4, 0, 1, 0, 0, 0, 0, 0, 0,  0, 1, 1, 'hB0, 5, 0);
    tab[16] = mk(1, 4, 0, 1, 0, 0, 0, 0, 0, 1,  0, 0, 1, 'hB0, 5, 0);
    tab[17] = mk(1, 4, 0, 1, 0, 0, 0, 0, 0, 0,  0, 0, 1, 'hB0, 5, 0);
    tab[18] = mk(1, 4, 0, 1, 0, 0, 0, 0, 0, 0,  0, 1, 1, 'hB0, 6, 0);
    tab[19] = mk(1, 4, 0, 1, 0, 0, 0, 1, 4, 0,  0, 1, 1, 'hA0, 7, 0);
    tab[20] = mk(1, 4, 0, 1, 0, 0, 0, 0, 0, 0,  1, 0, 0, 'hA0, 7, 0);
    tab[21] = mk(0, 0, 0, 0, 0, 0, 0, 1, 9, 0,  0, 0, 0, 'hA0, 7, 1);
    tab[22] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0,  0, 0, 0, 'hA0, 7, 1);
    tab[23] = mk(1, 0, 0, 0, 0, 6, 1, 0, 0, 1,  0, 0, 1, 'hA0, 7, 1);
    tab[24] = mk(1, 0, 0, 0, 0, 6, 1, 0, 0, 0,  0, 0, 1, 'hA0, 7, 1);
    tab[25] = mk(1, 0, 0, 0, 0, 6, 1, 0, 0, 0,  1, 0, 0, 'hE0, 7, 1);
    tab[26] = mk(1, 5, 0, 1, 0, 0, 0, 0, 0, 0,  1, 0, 0, 'h00, 0, 0);

    drive(tab[0]);
    reset = 1'b1;
    model_reset();
    #12;
    chk("reset busy_mask", bus.busy_mask, 32'h0);
    chk("reset stall_cnt", 32'(bus.stall_cnt), 32'h0);
    chk("reset err", 32'(bus.err_underflow), 32'h0);
    chk("reset issue", 32'(bus.issue), 32'h0);
    chk("reset bubble_ex", 32'(bus.bubble_ex), 32'h0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 26; i++) step(tab[i], 1'b1, $sformatf("vec%0d", i));

    // Reset asserted while r5 is saturated and decode is stalled on it
    @(negedge clk);
    rv = mk(1, 5, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    drive(rv);
    #1;
    chk("pre-reset stall_if", 32'(bus.stall_if), 32'h1);
    #2;
    reset = 1'b1;
    #1;
    chk("midreset busy_mask", bus.busy_mask, 32'h0);
    chk("midreset stall_cnt", 32'(bus.stall_cnt), 32'h0);
    chk("midreset err", 32'(bus.err_underflow), 32'h0);
    chk("midreset stall_if", 32'(bus.stall_if), 32'h0);
    bus.id_valid = 1'b0;
    #1;
    chk("midreset issue", 32'(bus.issue), 32'h0);
    chk("midreset bubble_ex", 32'(bus.bubble_ex), 32'h0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    step(tab[26], 1'b1, "postreset");

    // Randomized traffic over r0..r7 against the model
    for (int n = 0; n < 3000; n++) begin
      rv = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      rv.v   = ($urandom_range(0, 3) != 0);
      rv.rs  = 5'($urandom_range(0, 7));
      rv.rt  = 5'($urandom_range(0, 7));
      rv.rsu = 1'($urandom_range(0, 1));
      rv.rtu = 1'($urandom_range(0, 1));
      rv.dst = 5'($urandom_range(0, 7));
      rv.wr  = 1'($urandom_range(0, 1));
      rv.fl  = ($urandom_range(0, 9) == 0);
      rv.wbv = ($urandom_range(0, 2) != 0);
      nc = 0;
      for (int j = 1; j < 8; j++) if (pend[j] > 0) begin cand[nc] = j; nc++; end
      if (nc > 0 && $urandom_range(0, 19) != 0)
        rv.wba = 5'(cand[$urandom_range(0, nc - 1)]);
      else
        rv.wba = 5'($urandom_range(0, 7));
      step(rv, 1'b0, $sformatf("rnd%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
